// File: rtl/maprom_pkg.sv
// Shared definitions for the maprom CPLD: shadow ROM window, control page and FSM encodings.
package maprom_pkg;

    localparam logic [23:0] MAPROM_BASE  = 24'hF80000;
    localparam int unsigned MAPROM_BYTES = 32'h0008_0000;
    localparam logic [23:0] CTRL_PAGE    = 24'hE9C000;

    typedef enum logic [2:0] {
        L_IDLE,
        L_WAITSRC,
        L_REQ,
        L_ACK,
        L_CYCLE,
        L_NEXT,
        L_REL
    } load_state_e;

    typedef enum logic [1:0] {
        C_IDLE,
        C_AS,
        C_DS,
        C_END
    } cyc_state_e;

endpackage

// File: rtl/m68k_cycle_gen.sv
// Single 68000 bus cycle: AS, then UDS/LDS, wait for DTACK or give up after TIMEOUT clocks.
// With MAPROM_VERIFY_EN the data bus is captured while DTACK is low.
module m68k_cycle_gen
    import maprom_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        _RST,
    input  logic        start,
    input  logic        DTACK_n,
`ifdef MAPROM_VERIFY_EN
    input  logic [15:0] d_in,
    output logic [15:0] rd_data,
`endif
    output logic        AS_n,
    output logic        UDS_n,
    output logic        LDS_n,
    output logic        cyc_end,
    output logic        cyc_abort
);

    localparam int TM_W = $clog2(TIMEOUT + 1);

    cyc_state_e        state, state_d;
    logic [TM_W-1:0]   ds_cnt;
    logic              ds_run;

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state  <= C_IDLE;
            ds_cnt <= '0;
        end else begin
            // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
            state  <= state_d;
            ds_cnt <= ds_run ? ds_cnt + TM_W'(1) : '0;
        end
    end

`ifdef MAPROM_VERIFY_EN
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST)
            rd_data <= '0;
        else if (state == C_DS && !DTACK_n)
            rd_data <= d_in;
    end
`endif

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case leaves a latch.
        state_d   = state;
        AS_n      = 1'b1;
        UDS_n     = 1'b1;
        LDS_n     = 1'b1;
        cyc_end   = 1'b0;
        cyc_abort = 1'b0;
        ds_run    = 1'b0;
        case (state)
            C_IDLE: if (start) state_d = C_AS;
            C_AS: begin
                AS_n    = 1'b0;
                state_d = C_DS;
            end
            C_DS: begin
                AS_n  = 1'b0;
                UDS_n = 1'b0;
                LDS_n = 1'b0;
                // Data strobes stay low at least two clocks: a 4-clock minimum from address valid.
                if (!DTACK_n && ds_cnt != '0) begin
                    state_d = C_END;
                end else if (ds_cnt == TM_W'(TIMEOUT - 1)) begin
                    cyc_abort = 1'b1;
                    state_d   = C_IDLE;
                end else begin
                    ds_run = 1'b1;
                end
            end
            C_END: begin
                cyc_end = 1'b1;
                state_d = C_IDLE;
            end
            default: state_d = C_IDLE;
        endcase
    end

endmodule

// File: rtl/maprom_loader.sv
// Bus-mastering loader: streams source words into the shadow ROM window with real 68000 write cycles.
// Define MAPROM_VERIFY_EN to read back every word and abort on mismatch (adds D_in / fail_addr).
module maprom_loader
    import maprom_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR = MAPROM_BASE,
    parameter int unsigned WORDS     = 262144,
    parameter int unsigned BURST     = 64,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        CLK,
    input  logic        _RST,
    input  logic        start,
    input  logic [15:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic        BR_n,
    input  logic        BG_n,
    output logic        BGACK_n,
    input  logic        AS_n_in,
    input  logic        DTACK_n,
    output logic        bus_oe,
    output logic [23:1] A,
    output logic [15:0] D,
    output logic        AS_n,
    output logic        UDS_n,
    output logic        LDS_n,
    output logic        RW,
`ifdef MAPROM_VERIFY_EN
    input  logic [15:0] D_in,
    output logic [23:1] fail_addr,
`endif
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int WC_W = $clog2(WORDS + 1);
    localparam int BC_W = $clog2(BURST + 1);
    localparam int TM_W = $clog2(TIMEOUT + 1);

    load_state_e      state, state_d;
    logic             owned;
    logic [23:1]      addr;
    logic [WC_W-1:0]  word_cnt;
    logic [BC_W-1:0]  burst_cnt;
    logic [TM_W-1:0]  tmr;
    logic [15:0]      data_q;

    logic load, latch, acquire, release_bus, step, stall_tick;
    logic set_done, set_err, clr_busy, cyc_start, cyc_end, cyc_abort;

`ifdef MAPROM_VERIFY_EN
    logic        rd_phase, rd_set, rd_clr, set_fail;
    logic [15:0] rd_data;
`endif

    m68k_cycle_gen #(.TIMEOUT(TIMEOUT)) u_cyc (
        .CLK       (CLK),
        ._RST      (_RST),
        .start     (cyc_start),
        .DTACK_n   (DTACK_n),
`ifdef MAPROM_VERIFY_EN
        .d_in      (D_in),
        .rd_data   (rd_data),
`endif
        .AS_n      (AS_n),
        .UDS_n     (UDS_n),
        .LDS_n     (LDS_n),
        .cyc_end   (cyc_end),
        .cyc_abort (cyc_abort)
    );

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state     <= L_IDLE;
            owned     <= 1'b0;
            addr      <= BASE_ADDR[23:1];
            word_cnt  <= '0;
            burst_cnt <= '0;
            tmr       <= '0;
            data_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_d;
            tmr   <= stall_tick ? tmr + TM_W'(1) : '0;
            if (load) begin
                addr      <= BASE_ADDR[23:1];
                word_cnt  <= '0;
                burst_cnt <= '0;
                busy      <= 1'b1;
                done      <= 1'b0;
                err       <= 1'b0;
            end
            if (latch)       data_q <= src_data;
            if (acquire)     owned  <= 1'b1;
            if (release_bus) owned  <= 1'b0;
            if (step) begin
                addr      <= addr + 23'd1;
                word_cnt  <= word_cnt + WC_W'(1);
                burst_cnt <= (burst_cnt == BC_W'(BURST - 1)) ? '0 : burst_cnt + BC_W'(1);
            end
            if (set_done) done <= 1'b1;
            if (set_err)  err  <= 1'b1;
            if (clr_busy) busy <= 1'b0;
        end
    end

`ifdef MAPROM_VERIFY_EN
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            rd_phase  <= 1'b0;
            fail_addr <= '0;
        end else begin
            if (rd_set)   rd_phase  <= 1'b1;
            if (rd_clr)   rd_phase  <= 1'b0;
            if (set_fail) fail_addr <= addr;
        end
    end
`endif

    always_comb begin
        state_d     = state;
        load        = 1'b0;
        latch       = 1'b0;
        acquire     = 1'b0;
        release_bus = 1'b0;
        step        = 1'b0;
        stall_tick  = 1'b0;
        set_done    = 1'b0;
        set_err     = 1'b0;
        clr_busy    = 1'b0;
        cyc_start   = 1'b0;
        src_ready   = 1'b0;
`ifdef MAPROM_VERIFY_EN
        rd_set      = 1'b0;
        rd_clr      = 1'b0;
        set_fail    = 1'b0;
`endif
        case (state)
            L_IDLE: if (start) begin
                load    = 1'b1;
                state_d = L_WAITSRC;
            end
            L_WAITSRC: begin
                if (src_valid) begin
                    latch   = 1'b1;
                    state_d = owned ? L_ACK : L_REQ;
                end else if (owned) begin
                    // A starved source must not hold the CPU off the bus indefinitely.
                    if (tmr == TM_W'(TIMEOUT - 1)) begin
                        release_bus = 1'b1;
                        state_d     = L_REL;
                    end else begin
                        stall_tick = 1'b1;
                    end
                end
            end
            L_REQ: if (!BG_n && AS_n_in && DTACK_n) begin
                acquire = 1'b1;
                state_d = L_ACK;
            end
            L_ACK: begin
                cyc_start = 1'b1;
                state_d   = L_CYCLE;
            end
            L_CYCLE: begin
                if (cyc_abort) begin
                    set_err     = 1'b1;
                    release_bus = 1'b1;
                    state_d     = L_REL;
                end else if (cyc_end) begin
`ifdef MAPROM_VERIFY_EN
                    if (!rd_phase) begin
                        src_ready = 1'b1;
                        rd_set    = 1'b1;
                        state_d   = L_ACK;
                    end else if (rd_data != data_q) begin
                        rd_clr      = 1'b1;
                        set_err     = 1'b1;
                        set_fail    = 1'b1;
                        release_bus = 1'b1;
                        state_d     = L_REL;
                    end else begin
                        rd_clr  = 1'b1;
                        step    = 1'b1;
                        state_d = L_NEXT;
                    end
`else
                    src_ready = 1'b1;
                    step      = 1'b1;
                    state_d   = L_NEXT;
`endif
                end
            end
            L_NEXT: begin
                if (word_cnt == WC_W'(WORDS)) begin
                    set_done    = 1'b1;
                    release_bus = 1'b1;
                    state_d     = L_REL;
                end else if (burst_cnt == '0) begin
                    release_bus = 1'b1;
                    state_d     = L_REL;
                end else begin
                    state_d = L_WAITSRC;
                end
            end
            L_REL: begin
                if (done || err) begin
                    clr_busy = 1'b1;
                    state_d  = L_IDLE;
                end else begin
                    state_d = L_WAITSRC;
                end
            end
            default: state_d = L_IDLE;
        endcase
    end

    assign BR_n    = (state != L_REQ);
    assign BGACK_n = ~owned;
    assign bus_oe  = owned;
    assign A       = addr;
    assign D       = data_q;
`ifdef MAPROM_VERIFY_EN
    // The external data driver is gated by bus_oe & ~RW, so D floats during the read-back.
    assign RW      = ~(owned & ~rd_phase);
`else
    assign RW      = ~owned;
`endif

endmodule

// File: tb/tb_maprom_loader.sv
// Directed bench for maprom_loader: WORDS=10, BURST=4 so a load spans three bus tenures.
// With MAPROM_VERIFY_EN the read-back mismatch path is exercised as well.
module tb_maprom_loader;

    localparam int WORDS = 10;

    logic        CLK = 1'b0;
    logic        _RST;
    logic        start;
    logic [15:0] src_data = 16'h1000;
    logic        src_valid;
    logic        src_ready;
    logic        BR_n;
    logic        BG_n = 1'b1;
    logic        BGACK_n;
    logic        AS_n_in;
    logic        DTACK_n = 1'b1;
    logic        bus_oe;
    logic [23:1] A;
    logic [15:0] D;
    logic        AS_n, UDS_n, LDS_n, RW;
    logic        busy, done, err;
`ifdef MAPROM_VERIFY_EN
    logic [15:0] D_in = 16'h0000;
    logic [23:1] fail_addr;
    logic        corrupt_en = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    int grant_mode = 0;     // 0: BG follows BR, 1: BG held high, 2: BG held low
    logic dtack_en = 1'b1;

    int          wr_cnt = 0;
    int          srdy_cnt = 0;
    int          bgack_falls = 0;
    int          br_falls = 0;
    logic [23:0] wr_addr [0:255];
    logic [15:0] wr_data [0:255];
    logic        uds_prev = 1'b1, bgack_prev = 1'b1, br_prev = 1'b1;

    maprom_loader #(
        .BASE_ADDR (24'hF80000),
        .WORDS     (WORDS),
        .BURST     (4),
        .TIMEOUT   (255)
    ) u_dut (
        .CLK       (CLK),
        ._RST      (_RST),
        .start     (start),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .BR_n      (BR_n),
        .BG_n      (BG_n),
        .BGACK_n   (BGACK_n),
        .AS_n_in   (AS_n_in),
        .DTACK_n   (DTACK_n),
        .bus_oe    (bus_oe),
        .A         (A),
        .D         (D),
        .AS_n      (AS_n),
        .UDS_n     (UDS_n),
        .LDS_n     (LDS_n),
        .RW        (RW),
`ifdef MAPROM_VERIFY_EN
        .D_in      (D_in),
        .fail_addr (fail_addr),
`endif
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    // Bus/arbiter/source models, all sampled and driven on the falling edge.
    always @(negedge CLK) begin
        if (!UDS_n && uds_prev && !RW && wr_cnt < 256) begin
            wr_addr[wr_cnt] = {A, 1'b0};
            wr_data[wr_cnt] = D;
            wr_cnt++;
        end
        if (!BGACK_n && bgack_prev) bgack_falls++;
        if (!BR_n && br_prev) br_falls++;
        uds_prev   = UDS_n;
        bgack_prev = BGACK_n;
        br_prev    = BR_n;
        if (src_ready) begin
            srdy_cnt++;
            src_data = 16'h1000 + 16'(srdy_cnt);
        end
        case (grant_mode)
            1:       BG_n = 1'b1;
            2:       BG_n = 1'b0;
            default: BG_n = BR_n;
        endcase
        DTACK_n = !(dtack_en && !UDS_n);
`ifdef MAPROM_VERIFY_EN
        D_in = (corrupt_en && A == 23'h7C0002) ? 16'hDEAD : D;
`endif
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic start_load(input string tag);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_finished"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wb, sb, gb, rb, n;
        _RST = 1'b0; start = 1'b0; src_valid = 1'b1; AS_n_in = 1'b1;
        repeat (2) @(negedge CLK);

        check("rst_bus_oe",  bus_oe,    0);
        check("rst_br",      BR_n,      1);
        check("rst_bgack",   BGACK_n,   1);
        check("rst_as",      AS_n,      1);
        check("rst_uds",     UDS_n,     1);
        check("rst_lds",     LDS_n,     1);
        check("rst_rw",      RW,        1);
        check("rst_srdy",    src_ready, 0);
        check("rst_busy",    busy,      0);
        check("rst_done",    done,      0);
        check("rst_err",     err,       0);
        check("rst_addr",    A,         23'h7C0000);
        _RST = 1'b1;
        @(negedge CLK);

        // Full load, grant immediately, DTACK half a clock after the data strobes.
        wb = wr_cnt; sb = srdy_cnt; gb = bgack_falls; rb = br_falls;
        start_load("norm");
        wait_idle("norm", 3000);
        check("norm_writes",  wr_cnt - wb,      WORDS);
        check("norm_srdy",    srdy_cnt - sb,    WORDS);
        check("norm_tenures", bgack_falls - gb, 3);
        check("norm_br",      br_falls - rb,    3);
        check("norm_done",    done,   1);
        check("norm_err",     err,    0);
        check("norm_bus_oe",  bus_oe, 0);
        for (int k = 0; k < WORDS; k++) begin
            check($sformatf("norm_addr%0d", k), wr_addr[wb + k], 24'hF80000 + 24'(2 * k));
            check($sformatf("norm_data%0d", k), wr_data[wb + k], 16'h1000 + 16'(sb + k));
        end

        // Grant withheld, then given while another master still has AS asserted.
        grant_mode = 1;
        start_load("grant");
        repeat (20) @(negedge CLK);
        check("grant_br_req",     BR_n,    0);
        check("grant_no_ack",     BGACK_n, 1);
        AS_n_in = 1'b0; grant_mode = 2;
        repeat (3) @(negedge CLK);
        check("grant_as_busy",    BGACK_n, 1);
        AS_n_in = 1'b1;
        repeat (2) @(negedge CLK);
        check("grant_ack",        BGACK_n, 0);
        grant_mode = 0;
        wait_idle("grant", 3000);
        check("grant_done",       done, 1);

        // DTACK never arrives.
        dtack_en = 1'b0;
        sb = srdy_cnt;
        start_load("dtk");
        repeat (200) @(negedge CLK);
        check("dtk_err_early", err, 0);
        n = 0;
        while (!err && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check("dtk_err", err, 1);
        repeat (3) @(negedge CLK);
        check("dtk_busy",   busy,    0);
        check("dtk_bus_oe", bus_oe,  0);
        check("dtk_bgack",  BGACK_n, 1);
        check("dtk_as",     AS_n,    1);
        check("dtk_uds",    UDS_n,   1);
        check("dtk_lds",    LDS_n,   1);
        check("dtk_done",   done,    0);
        check("dtk_srdy",   srdy_cnt - sb, 0);
        dtack_en = 1'b1;

        // Reset in the middle of the second word.
        wb = wr_cnt; sb = srdy_cnt;
        start_load("rstmid");
        n = 0;
        while (wr_cnt < wb + 2 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check("rstmid_reached", wr_cnt - wb, 2);
        #2 _RST = 1'b0;
        #1;
        check("rstmid_bus_oe", bus_oe,  0);
        check("rstmid_uds",    UDS_n,   1);
        check("rstmid_as",     AS_n,    1);
        check("rstmid_bgack",  BGACK_n, 1);
        check("rstmid_br",     BR_n,    1);
        check("rstmid_busy",   busy,    0);
        check("rstmid_srdy_o", src_ready, 0);
        @(negedge CLK);
        _RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rstmid_srdy", srdy_cnt - sb, 1);
        wb = wr_cnt; sb = srdy_cnt;
        start_load("restart");
        wait_idle("restart", 3000);
        check("restart_addr", wr_addr[wb], 24'hF80000);
        check("restart_data", wr_data[wb], 16'h1000 + 16'(sb));
        check("restart_done", done, 1);

        // Source stalls while the bus is held: bus is released, load still completes.
        wb = wr_cnt; sb = srdy_cnt;
        start_load("stall");
        n = 0;
        while (srdy_cnt < sb + 2 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        src_valid = 1'b0;
        repeat (300) @(negedge CLK);
        check("stall_released", BGACK_n, 1);
        check("stall_busy",     busy,    1);
        check("stall_err",      err,     0);
        src_valid = 1'b1;
        wait_idle("stall", 3000);
        check("stall_writes", wr_cnt - wb,   WORDS);
        check("stall_srdy",   srdy_cnt - sb, WORDS);
        check("stall_done",   done, 1);
        check("stall_err2",   err,  0);

`ifdef MAPROM_VERIFY_EN
        // Read-back of F80004 returns a corrupted word.
        corrupt_en = 1'b1;
        wb = wr_cnt; sb = srdy_cnt;
        start_load("vfy");
        wait_idle("vfy", 3000);
        check("vfy_err",    err,       1);
        check("vfy_done",   done,      0);
        check("vfy_addr",   fail_addr, 23'h7C0002);
        check("vfy_writes", wr_cnt - wb,   3);
        check("vfy_srdy",   srdy_cnt - sb, 3);
        corrupt_en = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maprom_loader.md
Name: maprom_loader

Overview:
- Autonomous 68000 bus initiator on the A500 side of the RAM/maprom CPLD.
- Takes a word stream from an upstream source (flash reader) and writes it into the F80000–FFFFFF shadow ROM window with genuine CPU-style write cycles, so the existing maprom responder arms exactly as it does for software writes.
- Arbitrates for the bus with BR/BG/BGACK and releases it periodically so the CPU and chipset are not starved.

Parameters:
- BASE_ADDR, 24'hF80000, first byte address written (word aligned).
- WORDS, 262144, number of 16-bit words per load (512 KB).
- BURST, 64, words transferred per bus tenure before BGACK is released.
- TIMEOUT, 255, clocks waited for DTACK before aborting with error.

Ports:
- CLK  in  1  CPU clock (7.09 MHz); all logic on rising edge.
- _RST  in  1  reset.
- start  in  1  one-clock pulse; begins a load when idle.
- src_data  in  16  next word to write.
- src_valid  in  1  src_data valid.
- src_ready  out  1  word consumed this clock.
- BR_n  out  1  bus request.
- BG_n  in  1  bus grant.
- BGACK_n  out  1  bus grant acknowledge.
- AS_n_in  in  1  bus address strobe, monitored.
- DTACK_n  in  1  data transfer acknowledge.
- bus_oe  out  1  enables A/D/AS/UDS/LDS/RW drivers.
- A  out  23  address A[23:1].
- D  out  16  write data.
- AS_n, UDS_n, LDS_n  out  1 each  strobes.
- RW  out  1  always 0 while driving.
- busy, done, err  out  1 each  status.

Behaviour:
- Reset: _RST asynchronous, active-low. All strobes, BR_n and BGACK_n are high. bus_oe=0, RW=1, src_ready=0, busy=done=err=0, address counter = BASE_ADDR, word counter = 0.
- States:
  - IDLE: wait for start; clears done/err, loads counters.
  - WAITSRC: wait for src_valid.
  - REQ: BR_n=0; wait for BG_n=0 with AS_n_in=1 and DTACK_n=1, each sampled on the same clock.
  - ACK: BGACK_n=0, BR_n=1, bus_oe=1, RW=0, A and D valid.
  - S_AS: AS_n=0.
  - S_DS: UDS_n=LDS_n=0; wait for DTACK_n=0.
  - S_END: all strobes high; src_ready=1 for exactly one clock; word counter +1; address +2.
  - NEXT:
    - word counter = WORDS: go to REL and set done.
    - word counter mod BURST = 0: go to REL, then WAITSRC.
    - otherwise: go to WAITSRC, keeping BGACK.
  - REL: bus_oe=0, BGACK_n=1, one clock; then IDLE or WAITSRC.
- Timing:
  - Minimum write cycle is 4 clocks from A valid to strobes negated.
  - Strobes are high for at least 1 clock between words, so every word produces a UDS falling edge.
- Data stalls: src_valid low while the bus is held lets BGACK stay asserted for at most TIMEOUT clocks, then the bus is released (REL) and re-requested later. This is not an error.
- DTACK timeout: TIMEOUT clocks in S_DS without DTACK gives err=1 and busy=0. Strobes are negated and the bus released; the abort returns to IDLE.
- start while busy: ignored.
- _RST asserted mid-cycle: drivers are released on the same edge, the transfer is abandoned, and the source is not acknowledged.
- Address wrap: the counter is 23 bits and wraps silently. BASE_ADDR + 2*WORDS beyond 24'hFFFFFF is a configuration error and is not checked.
- busy=1 from the clock after start until REL completes the last word or an abort.

Optional Feature:
- MAPROM_VERIFY_EN defined:
  - After each write, an extra read cycle runs to the same address (RW=1, bus_oe drives address/strobes only; D not driven).
  - The data bus is sampled on DTACK via an added input port D_in[15:0] and compared with the written word.
  - On mismatch, err=1, the failing address is held in output fail_addr[23:1], and the load aborts.
- Undefined: no read cycle, and D_in/fail_addr are absent.

Decomposition:
- Shared package maprom_pkg holds:
  - the state enum;
  - the F80000 window base/size constants, also used by the responder;
  - the E9C000 control page constant.
- One sub-module: m68k_cycle_gen, which runs a single read or write bus cycle (strobe sequencing, DTACK wait, timeout).
  - The loader FSM owns arbitration, counters and the source handshake.

Test Plan:
- WORDS=4, BURST=64, source always valid, DTACK 1 clock after strobes:
  - exactly 4 writes at F80000, F80002, F80004, F80006 with matching data, one BR/BGACK tenure;
  - done=1, src_ready pulses=4.
- WORDS=130, BURST=64: three tenures (64, 64, 2 words); BGACK_n high for at least 1 clock between them; BR re-asserted each time.
- Grant held off: BG_n high 20 clocks, then low while AS_n_in=0 for 3 clocks. BGACK is asserted only after AS_n_in returns high.
- DTACK never asserted: after 255 clocks in S_DS, err=1, busy=0, bus_oe=0, strobes high, src_ready never pulsed.
- _RST pulsed low during word 2: all outputs return to reset values immediately. A following start restarts at F80000.
- MAPROM_VERIFY_EN, bus model returns 16'hDEAD for a written 16'hBEEF at F80004: err=1, fail_addr=F80004>>1, no further writes.
